// File: rtl/ps2_key_decoder_if.sv
// Scan-code input strobe and key-event FIFO handshake between the PS/2
// byte source, the decoder and the event consumer.
interface ps2_key_decoder_if;
  logic       code_valid;
  logic [7:0] code_data;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_ascii;
  logic [7:0] ev_code;
  logic       ev_release;
  logic       ev_ext;

  // Byte source / event consumer side
  modport master (
    output code_valid, code_data, ev_ready,
    input  ev_valid, ev_ascii, ev_code, ev_release, ev_ext
  );

  // Decoder side
  modport slave (
    input  code_valid, code_data, ev_ready,
    output ev_valid, ev_ascii, ev_code, ev_release, ev_ext
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: resolves E0/F0 prefixes, tracks Shift/Ctrl/
// CapsLock, translates key events to ASCII and queues them in a show-ahead FIFO.
module ps2_key_decoder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_key_decoder_if.slave     bus,
  output logic [2:0]           mods,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } event_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          shl_q, shr_q, ctl_q, ctr_q, caps_q;
  event_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  logic       is_e0, is_f0, is_ctl;
  logic       emit, emit_rel, emit_ext;
  logic [7:0] emit_ascii;
  logic       full, push, pop, drop;

  // Scan code to ASCII for non-extended keys; letters case-adjusted by upper
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic upper);
    logic [7:0] a;
    a = '0;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      default: a = '0;
    endcase
    if (a != '0) begin
      if (upper) a = a - 8'h20;
    end else begin
      case (c)
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08; 8'h0D: a = 8'h09;
        8'h76: a = 8'h1B;
        default: a = '0;
      endcase
    end
    return a;
  endfunction

  assign is_e0  = bus.code_data == 8'hE0;
  assign is_f0  = bus.code_data == 8'hF0;
  assign is_ctl = bus.code_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  // Decide whether the incoming byte completes a key event, and its flags
  always_comb begin
    emit     = 1'b0;
    emit_rel = 1'b0;
    emit_ext = 1'b0;
    if (bus.code_valid) begin
      unique case (state_q)
        IDLE:   emit = !(is_e0 || is_f0 || is_ctl);
        EXT:    begin emit = !(is_e0 || is_f0); emit_ext = 1'b1; end
        BRK:    begin emit = !(is_e0 || is_f0); emit_rel = 1'b1; end
        EXTBRK: begin emit = !(is_e0 || is_f0); emit_rel = 1'b1; emit_ext = 1'b1; end
        default: emit = 1'b0;
      endcase
    end
  end

  // ASCII is looked up against the modifier state before this event applies
  assign emit_ascii = emit_ext ? 8'h00
                    : to_ascii(bus.code_data, (shl_q | shr_q) ^ caps_q);

  // Prefix state machine with inter-byte timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else if (bus.code_valid) begin
      timer_q <= '0;
      unique case (state_q)
        IDLE:    if (is_e0) state_q <= EXT; else if (is_f0) state_q <= BRK;
        EXT:     if (is_f0) state_q <= EXTBRK; else if (!is_e0) state_q <= IDLE;
        BRK:     if (!(is_e0 || is_f0)) state_q <= IDLE;
        EXTBRK:  if (!(is_e0 || is_f0)) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == TW'(TIMEOUT - 1)) begin
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  // Modifier tracking; updates on every emitted event, even when it is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shl_q  <= 1'b0;
      shr_q  <= 1'b0;
      ctl_q  <= 1'b0;
      ctr_q  <= 1'b0;
      caps_q <= 1'b0;
    end else if (emit) begin
      if (!emit_ext) begin
        if (bus.code_data == 8'h12) shl_q <= !emit_rel;
        if (bus.code_data == 8'h59) shr_q <= !emit_rel;
        if (bus.code_data == 8'h14) ctl_q <= !emit_rel;
        if (bus.code_data == 8'h58 && !emit_rel) caps_q <= !caps_q;
      end else if (bus.code_data == 8'h14) begin
        ctr_q <= !emit_rel;
      end
    end
  end

  assign mods = {caps_q, ctl_q | ctr_q, shl_q | shr_q};

  assign full = cnt_q == (AW+1)'(DEPTH);
  assign pop  = bus.ev_valid & bus.ev_ready;
  assign push = emit & (!full | pop);
  assign drop = emit & full & !pop;

  // Event FIFO storage and pointers; storage is reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{ascii: emit_ascii, code: bus.code_data,
                         rel: emit_rel, ext: emit_ext};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky overflow flag; a drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  assign bus.ev_valid = cnt_q != '0;
  assign {bus.ev_ascii, bus.ev_code, bus.ev_release, bus.ev_ext} = mem_q[rd_q];

endmodule
